// File: rtl/pdm_pkg.sv
// Shared types and arithmetic helpers for the multi-channel PDM modulator.
package pdm_pkg;

    typedef enum logic {
        ORDER_1 = 1'b0,
        ORDER_2 = 1'b1
    } order_e;

    function automatic int maxp(input int w);
        return (1 << (w - 1)) - 1;
    endfunction

    function automatic int minn(input int w);
        return -(1 << (w - 1));
    endfunction

    // Adds two values and clamps the result to a w-bit signed range.
    function automatic int sat_add(input int a, input int b, input int w);
        int s;
        s = a + b;
        if (s > maxp(w)) return maxp(w);
        if (s < minn(w)) return minn(w);
        return s;
    endfunction

endpackage

// File: rtl/pdm_multi_if.sv
// Sample-write bus and status lines of the PDM block, grouped for benches and wrappers.
interface pdm_multi_if #(
    parameter int NUM_CH  = 2,
    parameter int WIDTH   = 8,
    parameter int CH_BITS = 1
);
    logic                     tick;
    logic                     order;
    logic [NUM_CH-1:0]        enable;
    logic                     valid;
    logic [CH_BITS-1:0]       chan;
    logic signed [WIDTH-1:0]  data;
    logic                     ready;
    logic                     clear;
    logic [NUM_CH-1:0]        underrun;
    logic [NUM_CH-1:0]        pdm;

    modport master (
        output tick, order, enable, valid, chan, data, clear,
        input  ready, underrun, pdm
    );

    modport slave (
        input  tick, order, enable, valid, chan, data, clear,
        output ready, underrun, pdm
    );
endinterface

// File: rtl/pdm_channel_core.sv
// One channel's sigma-delta integrators: first order in i2 alone, or second order with
// saturating i1/i2. Integrators clear on a mode change and stay at zero while disabled.
module pdm_channel_core
    import pdm_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic                    tick_in,
    input  logic                    enable_in,
    input  logic                    mode_change_in,
    input  order_e                  order_in,
    input  logic signed [WIDTH-1:0] level_in,
    output logic                    pdm_out
);

    logic signed [WIDTH+1:0] i1_q, i1_d;
    logic signed [WIDTH+3:0] i2_q, i2_d;
    logic signed [WIDTH:0]   acc_cur;
    logic                    y;
    int                      fb, acc, i1n, i2n;

    always_comb begin
        y       = ~i2_q[WIDTH+3];
        fb      = y ? maxp(WIDTH) : minn(WIDTH);
        acc_cur = i2_q[WIDTH:0];
        acc     = 0;
        i1n     = 0;
        i2n     = 0;
        i1_d    = i1_q;
        i2_d    = i2_q;
        if (!enable_in) begin
            i1_d = '0;
            i2_d = '0;
        end else if (tick_in) begin
            if (mode_change_in) begin
                i1_d = '0;
                i2_d = '0;
            end else if (order_in == ORDER_1) begin
                // First order reuses i2 as a sign-extended WIDTH+1 bit accumulator.
                acc  = int'(acc_cur) + int'(level_in) - fb;
                i2_d = acc[WIDTH+3:0];
                i1_d = '0;
            end else begin
                i1n  = sat_add(int'(i1_q), int'(level_in) - fb, WIDTH + 2);
                i2n  = sat_add(int'(i2_q), i1n - fb, WIDTH + 4);
                i1_d = i1n[WIDTH+1:0];
                i2_d = i2n[WIDTH+3:0];
            end
        end
        pdm_out = enable_in & y;
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            i1_q <= '0;
            i2_q <= '0;
        end else begin
            i1_q <= i1_d;
            i2_q <= i2_d;
        end
    end

endmodule

// File: rtl/pdm_multi.sv
// N-channel PDM: channel-addressed double-buffered sample staging, coherent commit on
// the sample tick, sticky underrun flags and one modulator core per channel.
module pdm_multi
    import pdm_pkg::*;
#(
    parameter int NUM_CH  = 2,
    parameter int WIDTH   = 8,
    parameter int CH_BITS = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic                    tick_in,
    input  logic                    order_in,
    input  logic [NUM_CH-1:0]       enable_in,
    input  logic                    sample_valid_in,
    input  logic [CH_BITS-1:0]      sample_chan_in,
    input  logic signed [WIDTH-1:0] sample_data_in,
    output logic                    sample_ready_out,
    input  logic                    underrun_clear_in,
    output logic [NUM_CH-1:0]       underrun_out,
    output logic [NUM_CH-1:0]       pdm_out
);

    logic signed [WIDTH-1:0] staged_q [NUM_CH];
    logic signed [WIDTH-1:0] staged_d [NUM_CH];
    logic signed [WIDTH-1:0] level_q  [NUM_CH];
    logic signed [WIDTH-1:0] level_d  [NUM_CH];
    logic [NUM_CH-1:0]       pending_q, pending_d;
    logic [NUM_CH-1:0]       underrun_q, underrun_d;
    order_e                  mode_q, mode_d;
    logic                    chan_ok, sel_pending, accept, mode_change;

    always_comb begin
        chan_ok     = (int'(sample_chan_in) < NUM_CH);
        sel_pending = 1'b0;
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            if (sample_chan_in == CH_BITS'(c)) sel_pending = pending_q[c];
        end
        sample_ready_out = chan_ok ? (~sel_pending | tick_in) : 1'b1;
        accept           = sample_valid_in & sample_ready_out & chan_ok;
        mode_change      = tick_in & (order_e'(order_in) != mode_q);
        mode_d           = tick_in ? order_e'(order_in) : mode_q;
        underrun_d       = underrun_q & ~{NUM_CH{underrun_clear_in}};
        pending_d        = pending_q;
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            staged_d[c] = staged_q[c];
            level_d[c]  = level_q[c];
            if (tick_in) begin
                if (pending_q[c]) begin
                    level_d[c]   = staged_q[c];
                    pending_d[c] = 1'b0;
                end else if (enable_in[c]) begin
                    underrun_d[c] = 1'b1;
                end
            end
            // A same-cycle write lands after the commit, so the old value moves to level.
            if (accept && sample_chan_in == CH_BITS'(c)) begin
                staged_d[c]  = sample_data_in;
                pending_d[c] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int unsigned c = 0; c < NUM_CH; c++) begin
                staged_q[c] <= '0;
                level_q[c]  <= '0;
            end
            pending_q  <= '0;
            underrun_q <= '0;
            mode_q     <= ORDER_1;
        end else begin
            for (int unsigned c = 0; c < NUM_CH; c++) begin
                staged_q[c] <= staged_d[c];
                level_q[c]  <= level_d[c];
            end
            pending_q  <= pending_d;
            underrun_q <= underrun_d;
            mode_q     <= mode_d;
        end
    end

    assign underrun_out = underrun_q;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        pdm_channel_core #(.WIDTH(WIDTH)) u_core (
            .clk_in         (clk_in),
            .rst_in         (rst_in),
            .tick_in        (tick_in),
            .enable_in      (enable_in[g]),
            .mode_change_in (mode_change),
            .order_in       (mode_q),
            .level_in       (level_q[g]),
            .pdm_out        (pdm_out[g])
        );
    end

endmodule

// File: tb/tb_pdm_multi.sv
// Self-checking bench for pdm_multi: hand-derived vector table plus a behavioural
// reference model feeding a scoreboard queue, and multi-cycle corner-case sequences.
module tb_pdm_multi;
    localparam int N    = 3;
    localparam int W    = 8;
    localparam int CB   = 2;
    localparam int MAXP = 127;
    localparam int MINN = -128;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pdm_multi_if #(.NUM_CH(N), .WIDTH(W), .CH_BITS(CB)) bus ();

    pdm_multi #(.NUM_CH(N), .WIDTH(W), .CH_BITS(CB)) dut (
        .clk_in            (clk),
        .rst_in            (rst),
        .tick_in           (bus.tick),
        .order_in          (bus.order),
        .enable_in         (bus.enable),
        .sample_valid_in   (bus.valid),
        .sample_chan_in    (bus.chan),
        .sample_data_in    (bus.data),
        .sample_ready_out  (bus.ready),
        .underrun_clear_in (bus.clear),
        .underrun_out      (bus.underrun),
        .pdm_out           (bus.pdm)
    );

    int n_cmp = 0;
    int n_bad = 0;

    int m_i1 [N];
    int m_i2 [N];
    int m_lvl[N];
    int m_stg[N];
    bit m_pend[N];
    bit m_und [N];
    bit m_mode;

    typedef struct {
        logic [N-1:0] pdm;
        logic [N-1:0] und;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        bit           tick;
        bit           valid;
        int           chan;
        int           data;
        bit           clr;
        bit           rdy;
        logic [N-1:0] pdm;
        logic [N-1:0] und;
    } vec_t;
    vec_t tbl[8];

    function automatic int clampv(input int v, input int bits);
        int hi, lo;
        hi = (1 << (bits - 1)) - 1;
        lo = -(1 << (bits - 1));
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

    function automatic void check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void check_range(input string name, input int act, input int lo, input int hi);
        n_cmp++;
        if (act < lo || act > hi) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
        end
    endfunction

    function automatic bit m_ready();
        int ch;
        ch = int'(bus.chan);
        if (ch >= N) return 1'b1;
        return !m_pend[ch] || bus.tick;
    endfunction

    function automatic logic [N-1:0] m_pdm();
        logic [N-1:0] p;
        for (int c = 0; c < N; c++) p[c] = bus.enable[c] && (m_i2[c] >= 0);
        return p;
    endfunction

    function automatic logic [N-1:0] m_undv();
        logic [N-1:0] u;
        for (int c = 0; c < N; c++) u[c] = m_und[c];
        return u;
    endfunction

    task automatic model_step();
        int ch, fb, i1n;
        bit acc_ok, mch, set;
        if (rst) begin
            for (int c = 0; c < N; c++) begin
                m_i1[c] = 0; m_i2[c] = 0; m_lvl[c] = 0; m_stg[c] = 0;
                m_pend[c] = 0; m_und[c] = 0;
            end
            m_mode = 0;
            return;
        end
        ch     = int'(bus.chan);
        acc_ok = bus.valid && m_ready() && (ch < N);
        mch    = bus.tick && (bus.order != m_mode);
        for (int c = 0; c < N; c++) begin
            fb = (m_i2[c] >= 0) ? MAXP : MINN;
            if (!bus.enable[c] || mch) begin
                m_i1[c] = 0;
                m_i2[c] = 0;
            end else if (bus.tick) begin
                if (!bus.order) begin
                    m_i2[c] = m_i2[c] + m_lvl[c] - fb;
                    m_i1[c] = 0;
                end else begin
                    i1n     = clampv(m_i1[c] + m_lvl[c] - fb, W + 2);
                    m_i2[c] = clampv(m_i2[c] + i1n - fb, W + 4);
                    m_i1[c] = i1n;
                end
            end
            set = 0;
            if (bus.tick) begin
                if (m_pend[c]) begin
                    m_lvl[c]  = m_stg[c];
                    m_pend[c] = 0;
                end else if (bus.enable[c]) begin
                    set = 1;
                end
            end
            if (set) m_und[c] = 1;
            else if (bus.clear) m_und[c] = 0;
        end
        if (bus.tick) m_mode = bus.order;
        if (acc_ok) begin
            m_stg[ch]  = int'(bus.data);
            m_pend[ch] = 1;
        end
    endtask

    // One clock: check ready before the edge, advance the model at the edge,
    // then compare the DUT against the queued expectation just after it.
    task automatic cycle();
        exp_t e;
        #1;
        check("ready", int'(bus.ready), int'(m_ready()));
        @(posedge clk);
        model_step();
        sb.push_back('{pdm: m_pdm(), und: m_undv()});
        #1;
        e = sb.pop_front();
        check("pdm", int'(bus.pdm), int'(e.pdm));
        check("underrun", int'(bus.underrun), int'(e.und));
    endtask

    task automatic idle_inputs();
        bus.tick  = 0;
        bus.valid = 0;
        bus.chan  = '0;
        bus.data  = '0;
        bus.clear = 0;
    endtask

    task automatic do_reset();
        rst = 1;
        cycle();
        rst = 0;
    endtask

    task automatic run_level(input int lvl, input bit ord, input int nticks, output int ones);
        idle_inputs();
        bus.enable = '0;
        do_reset();
        bus.order = ord;
        bus.valid = 1;
        bus.chan  = '0;
        bus.data  = W'(lvl);
        cycle();
        bus.valid = 0;
        bus.tick  = 1;
        cycle();
        bus.enable = 3'b001;
        ones = 0;
        for (int k = 0; k < nticks; k++) begin
            cycle();
            ones += int'(bus.pdm[0]);
        end
        bus.tick = 0;
    endtask

    initial begin
        int ones;
        tbl[0] = '{0, 1, 1, 10, 0, 1, 3'b011, 3'b000};
        tbl[1] = '{0, 1, 1, 20, 0, 0, 3'b011, 3'b000};
        tbl[2] = '{1, 1, 1, 20, 0, 1, 3'b000, 3'b001};
        tbl[3] = '{1, 0, 1, 0,  0, 1, 3'b011, 3'b001};
        tbl[4] = '{1, 0, 1, 0,  1, 1, 3'b000, 3'b011};
        tbl[5] = '{0, 0, 1, 0,  1, 1, 3'b000, 3'b000};
        tbl[6] = '{0, 1, 3, 55, 0, 1, 3'b000, 3'b000};
        tbl[7] = '{1, 0, 0, 0,  0, 1, 3'b011, 3'b011};

        idle_inputs();
        bus.order  = 0;
        bus.enable = 3'b011;
        rst        = 1;
        repeat (2) @(posedge clk);
        model_step();
        #1;
        rst = 0;
        check("reset_pdm", int'(bus.pdm), 3);
        check("reset_underrun", int'(bus.underrun), 0);

        for (int i = 0; i < 8; i++) begin
            bus.tick  = tbl[i].tick;
            bus.valid = tbl[i].valid;
            bus.chan  = CB'(tbl[i].chan);
            bus.data  = W'(tbl[i].data);
            bus.clear = tbl[i].clr;
            #1;
            check($sformatf("tbl%0d_ready", i), int'(bus.ready), int'(tbl[i].rdy));
            cycle();
            check($sformatf("tbl%0d_pdm", i), int'(bus.pdm), int'(tbl[i].pdm));
            check($sformatf("tbl%0d_und", i), int'(bus.underrun), int'(tbl[i].und));
        end

        // Reset mid-stream with a write and tick present in the reset cycle.
        bus.valid = 1; bus.chan = '0; bus.data = 8'sd50; bus.tick = 1;
        do_reset();
        idle_inputs();
        check("midrst_pdm", int'(bus.pdm), 3);
        check("midrst_und", int'(bus.underrun), 0);
        #1;
        check("midrst_ready", int'(bus.ready), 1);
        bus.valid = 1; bus.data = 8'sd7;
        cycle();
        #1;
        check("midrst_pending", int'(bus.ready), 0);
        bus.valid = 0;

        // Level 0 with a tick every cycle alternates 0,1,0,1 after the first tick.
        bus.enable = 3'b001;
        do_reset();
        bus.tick = 1;
        for (int k = 1; k <= 8; k++) begin
            cycle();
            check($sformatf("alt%0d", k), int'(bus.pdm[0]), (k % 2 == 0) ? 1 : 0);
        end
        bus.tick = 0;

        run_level(64, 0, 255, ones);
        check_range("o1_density64", ones, 191, 193);
        run_level(127, 0, 100, ones);
        check("o1_all_ones", ones, 100);
        run_level(-128, 0, 100, ones);
        check("o1_all_zeros", ones, 0);
        run_level(100, 1, 1024, ones);
        check_range("o2_density100", ones, 880, 930);
        run_level(127, 1, 1000, ones);
        check_range("o2_sat_pos", ones, 990, 1000);
        run_level(-128, 1, 1000, ones);
        check_range("o2_sat_neg", ones, 0, 10);

        // Order switch between ticks takes effect on the next tick as an integrator clear.
        run_level(-128, 0, 20, ones);
        check("pre_switch_pdm", int'(bus.pdm[0]), 0);
        bus.order = 1;
        cycle();
        check("switch_no_tick", int'(bus.pdm[0]), 0);
        bus.tick = 1;
        cycle();
        bus.tick = 0;
        check("switch_clear", int'(bus.pdm[0]), 1);

        bus.enable = 3'b000;
        #1;
        check("disable_pdm", int'(bus.pdm), 0);
        cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
